// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Fixed 33-cycle latency: one radix-2 step per cycle, then a sign-fix cycle.
module mult_div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t      state_r;
   logic [5:0]  cnt_r;
   logic        is_div_r;
   logic        sign_a_r;
   logic        sign_b_r;
   logic        div0_r;
   logic [31:0] opnd_r;
   logic [31:0] wh_r;
   logic [31:0] wl_r;

   logic        signed_s;
   logic [31:0] a_abs_s;
   logic [31:0] b_abs_s;
   logic [32:0] sum_s;
   logic [32:0] shift_s;
   logic [31:0] step_hi_s;
   logic [31:0] step_lo_s;
   logic        neg_s;
   logic [63:0] prod_fix_s;
   logic [31:0] fix_hi_s;
   logic [31:0] fix_lo_s;

   function automatic logic [31:0] abs32(input logic [31:0] v, input logic signed_op);
      if (signed_op && v[31]) begin
         abs32 = ~v + 32'd1;
      end else begin
         abs32 = v;
      end
   endfunction

   function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
      if (en) begin
         neg32 = ~v + 32'd1;
      end else begin
         neg32 = v;
      end
   endfunction

   // Operand conditioning for the start edge.
   always_comb begin
      signed_s = ~op[0];
      a_abs_s  = abs32(a, signed_s);
      b_abs_s  = abs32(b, signed_s);
   end

   // One radix-2 step: shift-add multiply or restoring divide.
   // Multiply: {wh,wl} holds partial product / multiplier; divide: wh=remainder, wl=dividend/quotient.
   always_comb begin
      sum_s     = {1'b0, wh_r} + {1'b0, opnd_r};
      shift_s   = {wh_r, wl_r[31]};
      step_hi_s = wh_r;
      step_lo_s = wl_r;
      if (is_div_r) begin
         if (shift_s >= {1'b0, opnd_r}) begin
            // The true difference is below the divisor, so 32 bits suffice.
            step_hi_s = shift_s[31:0] - opnd_r;
            step_lo_s = {wl_r[30:0], 1'b1};
         end else begin
            step_hi_s = shift_s[31:0];
            step_lo_s = {wl_r[30:0], 1'b0};
         end
      end else begin
         if (wl_r[0]) begin
            {step_hi_s, step_lo_s} = {sum_s, wl_r[31:1]};
         end else begin
            {step_hi_s, step_lo_s} = {1'b0, wh_r, wl_r[31:1]};
         end
      end
   end

   // Sign correction applied in FIX.
   always_comb begin
      neg_s      = sign_a_r ^ sign_b_r;
      prod_fix_s = {wh_r, wl_r};
      fix_hi_s   = wh_r;
      fix_lo_s   = wl_r;
      if (is_div_r) begin
         // Zero divisor leaves |a| in the remainder; re-signing it restores a.
         fix_hi_s = neg32(wh_r, sign_a_r);
         if (div0_r) begin
            fix_lo_s = 32'hFFFF_FFFF;
         end else begin
            fix_lo_s = neg32(wl_r, neg_s);
         end
      end else begin
         if (neg_s) begin
            prod_fix_s = ~{wh_r, wl_r} + 64'd1;
         end else begin
            prod_fix_s = {wh_r, wl_r};
         end
         fix_hi_s = prod_fix_s[63:32];
         fix_lo_s = prod_fix_s[31:0];
      end
   end

   // Control FSM with registered busy/done/hi/lo.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         cnt_r    <= 6'd0;
         is_div_r <= 1'b0;
         sign_a_r <= 1'b0;
         sign_b_r <= 1'b0;
         div0_r   <= 1'b0;
         opnd_r   <= 32'd0;
         wh_r     <= 32'd0;
         wl_r     <= 32'd0;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi       <= 32'd0;
         lo       <= 32'd0;
      end else begin
         done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  is_div_r <= op[1];
                  sign_a_r <= signed_s & a[31];
                  sign_b_r <= signed_s & b[31];
                  div0_r   <= (b == 32'd0);
                  opnd_r   <= op[1] ? b_abs_s : a_abs_s;
                  wl_r     <= op[1] ? a_abs_s : b_abs_s;
                  wh_r     <= 32'd0;
                  cnt_r    <= 6'd0;
                  busy     <= 1'b1;
                  state_r  <= CALC;
               end else begin
                  if (mthi) begin
                     hi <= wdata;
                  end
                  if (mtlo) begin
                     lo <= wdata;
                  end
               end
            end
            CALC: begin
               wh_r  <= step_hi_s;
               wl_r  <= step_lo_s;
               cnt_r <= cnt_r + 6'd1;
               if (cnt_r == 6'd31) begin
                  state_r <= FIX;
               end
            end
            FIX: begin
               hi      <= fix_hi_s;
               lo      <= fix_lo_s;
               done    <= 1'b1;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed expectations.
module tb_mult_div_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        mthi;
   logic        mtlo;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_cmp = 0;
   int n_err = 0;
   int since_start = 0;
   logic saw_done;

   mult_div_unit dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .mthi  (mthi),
      .mtlo  (mtlo),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      since_start = since_start + 1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      assert (obs === exp) else begin
         n_err = n_err + 1;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
      start = 1'b1;
      op    = o;
      a     = av;
      b     = bv;
      tick();
      since_start = 0;
      start = 1'b0;
      // Operands are don't-care after the start edge.
      op    = 2'b01;
      a     = 32'h5A5A_5A5A;
      b     = 32'h0000_0000;
   endtask

   task automatic wait_result(input string tag, input logic [31:0] eh, input logic [31:0] el);
      while (busy === 1'b1 && since_start < 40) begin
         tick();
      end
      chk({tag, " latency"}, since_start, 32'd33);
      chk({tag, " done"}, {31'd0, done}, 32'd1);
      chk({tag, " hi"}, hi, eh);
      chk({tag, " lo"}, lo, el);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      a     = 32'd0;
      b     = 32'd0;
      mthi  = 1'b0;
      mtlo  = 1'b0;
      wdata = 32'd0;
      tick();
      tick();
      rst = 1'b0;
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);
      chk("reset hi", hi, 32'd0);
      chk("reset lo", lo, 32'd0);

      // MTHI alone, then MTHI+MTLO together.
      mthi = 1'b1; wdata = 32'h1234_5678;
      tick();
      mthi = 1'b0;
      chk("mthi hi", hi, 32'h1234_5678);
      chk("mthi lo untouched", lo, 32'd0);
      mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_A5A5;
      tick();
      mthi = 1'b0; mtlo = 1'b0;
      chk("mthi+mtlo hi", hi, 32'hA5A5_A5A5);
      chk("mthi+mtlo lo", lo, 32'hA5A5_A5A5);

      // MULT -3*7 with a simultaneous MTHI that must be dropped.
      mthi = 1'b1; wdata = 32'hDEAD_BEEF;
      issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
      mthi = 1'b0;
      chk("mult busy", {31'd0, busy}, 32'd1);
      chk("mult hi hold", hi, 32'hA5A5_A5A5);
      wait_result("mult -3*7", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      tick();
      chk("mult done drop", {31'd0, done}, 32'd0);
      chk("mult idle", {31'd0, busy}, 32'd0);

      // MULTU max*max, then MULT of the same issued in the done cycle.
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_result("multu max", 32'hFFFF_FFFE, 32'h0000_0001);
      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("b2b accepted", {31'd0, busy}, 32'd1);
      wait_result("mult -1*-1", 32'h0000_0000, 32'h0000_0001);
      tick();

      // DIV -7/2 with MTLO and a second start injected mid-operation.
      issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
      tick(); tick(); tick(); tick();
      mtlo = 1'b1; wdata = 32'h1111_1111; start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3;
      tick();
      mtlo = 1'b0; start = 1'b0;
      chk("mid-div hi hold", hi, 32'h0000_0000);
      chk("mid-div lo hold", lo, 32'h0000_0001);
      wait_result("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      tick();
      chk("no relaunch", {31'd0, busy}, 32'd0);

      issue(2'b11, 32'h0000_0007, 32'h0000_0000);
      wait_result("divu 7/0", 32'h0000_0007, 32'hFFFF_FFFF);
      tick();
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_result("div min/-1", 32'h0000_0000, 32'h8000_0000);
      tick();
      issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0000);
      wait_result("div -7/0", 32'hFFFF_FFF9, 32'hFFFF_FFFF);
      tick();
      issue(2'b10, 32'd100, 32'hFFFF_FFF9);
      wait_result("div 100/-7", 32'h0000_0002, 32'hFFFF_FFF2);
      tick();
      issue(2'b11, 32'hFFFF_FFFF, 32'h0000_0010);
      wait_result("divu max/16", 32'h0000_000F, 32'h0FFF_FFFF);
      tick();

      // Reset in cycle 10 of a DIV aborts with no done pulse.
      issue(2'b10, 32'd100, 32'd7);
      while (since_start < 10) begin
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort busy", {31'd0, busy}, 32'd0);
      chk("abort hi", hi, 32'd0);
      chk("abort lo", lo, 32'd0);
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done === 1'b1) begin
            saw_done = 1'b1;
         end
      end
      chk("abort no done", {31'd0, saw_done}, 32'd0);
      chk("abort lo stays", lo, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high, with ports named clk and rst.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 start  in  1  request to begin an operation; sampled only in IDLE.
REQ-005 op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  in  32  rs operand (multiplicand or dividend).
REQ-007 b  in  32  rt operand (multiplier or divisor).
REQ-008 mthi  in  1  write wdata to HI (MTHI).
REQ-009 mtlo  in  1  write wdata to LO (MTLO).
REQ-010 wdata  in  32  data for mthi/mtlo.
REQ-011 busy  out  1  high while an operation is in progress.
REQ-012 done  out  1  one-cycle pulse when HI/LO receive a new result.
REQ-013 hi  out  32  HI register; feeds the downstream 32-bit 2:1 HI/LO select mux for MFHI/MFLO.
REQ-014 lo  out  32  LO register.

Function
REQ-015 States SHALL be IDLE, CALC and FIX; busy SHALL equal (state != IDLE).
REQ-016 In IDLE with start=1 at edge E0, the block SHALL latch op, |a| and |b| (absolute values for signed ops, raw values for unsigned ops), record the operand signs, clear the 6-bit iteration counter, and go to CALC.
REQ-017 CALC SHALL perform one radix-2 step per cycle (shift-add multiply or restoring divide) for exactly 32 cycles (edges E1..E32), then go to FIX.
REQ-018 At edge E33, FIX SHALL apply sign correction, write HI/LO, assert done for the following cycle only, and return to IDLE.
REQ-019 Fixed latency SHALL be 33 cycles from the start edge to the result on hi/lo for every op, including divide-by-zero.
REQ-020 MULT/MULTU SHALL produce the 64-bit product as {hi,lo}: two's-complement for MULT, unsigned for MULTU.
REQ-021 DIV/DIVU SHALL set lo=quotient and hi=remainder; for DIV the quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-022 For DIV 0x80000000 / 0xFFFFFFFF the block SHALL produce lo=0x80000000 and hi=0x00000000.
REQ-023 For divide by zero (b=0, DIV or DIVU) the block SHALL produce lo=0xFFFFFFFF and hi=a unmodified.
REQ-024 start, mthi and mtlo SHALL be ignored while busy=1, and hi/lo SHALL hold their previous values until FIX.
REQ-025 In IDLE without start, mthi/mtlo SHALL write wdata to hi/lo at the next edge; if both are asserted, both registers SHALL be written.
REQ-026 If start and mthi/mtlo are asserted together in IDLE, start SHALL take priority and the mthi/mtlo write SHALL be dropped.
REQ-027 start asserted in the cycle where done=1 SHALL be accepted, because the state is then IDLE, giving back-to-back operations every 34 cycles.
REQ-028 Operand inputs a, b and op SHALL be don't-care after E0; the block SHALL use only the latched copies.

Reset
REQ-029 With rst=1 at an edge, the block SHALL set state=IDLE, hi=0, lo=0, busy=0, done=0 and counter=0, regardless of the current state.
REQ-030 Reset SHALL override start, mthi and mtlo in the same cycle.
REQ-031 Reset during CALC or FIX SHALL abort the operation with no done pulse and no HI/LO result write.

Verification
REQ-032 MULT a=0xFFFFFFFD, b=0x00000007 -> busy high 33 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFEB; done high exactly 1 cycle.
REQ-033 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; MULT with the same operands -> hi=0x00000000, lo=0x00000001.
REQ-034 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=0x00000007; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 mthi wdata=0x12345678 in IDLE -> hi=0x12345678 next cycle; mtlo and a second start pulsed mid-DIV -> both ignored and the original result delivered; start issued during the done cycle -> accepted.
REQ-036 rst asserted at cycle 10 of a DIV -> next cycle busy=0, hi=lo=0, and no done pulse ever appears for that operation.
